round_key_sequencer: RTL and testbench
======================================

// Module: round_key_sequencer
// PURPOSE
//   Sequential AES-128 key schedule. Accepts a cipher key through a valid/ready handshake.
//   Runs one round-key expansion per clock (RotWord/SubWord/Rcon) over NR cycles.
//   Stores all NR+1 round keys in an internal buffer and serves them to the cipher/decipher
//   datapath through a registered indexed read port. Sits between key load and the round
//   pipeline, so round keys are precomputed once per key, not recomputed per block.
// PARAMETERS
//   NK    4       key length in 32-bit words; only 4 is supported, any other value is an elaboration error
//   NR    NK+6    number of rounds; buffer depth is NR+1 = 11 entries
//   RK_W  32*NK   round-key width in bits (128)
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   key_in        in   [0:127] cipher key; word0 = key_in[0:31] (big-endian byte order)
//   key_valid     in   1      key_in valid
//   key_ready     out  1      block can accept a key
//   busy          out  1      expansion in progress
//   keys_ready    out  1      all NR+1 round keys are valid in the buffer
//   rk_idx        in   [3:0]  round-key index to read, 0..NR
//   rk_out        out  [0:127] registered round key for the rk_idx sampled in the previous cycle
//   rk_out_valid  out  1      rk_out holds a valid key
// BEHAVIOUR
//   Reset (async, rst_n=0): FSM=IDLE, round counter=0, all buffer entries=0, key_ready=1,
//     busy=0, keys_ready=0, rk_out=0, rk_out_valid=0. Reset mid-expansion discards all keys.
//   FSM states are IDLE, EXPAND and DONE.
//     IDLE: key_ready=1. On key_valid&key_ready: buf[0]<=key_in, cnt<=1, go to EXPAND.
//     EXPAND: key_ready=0, busy=1. Each cycle buf[cnt]<=expand(buf[cnt-1],cnt), cnt<=cnt+1.
//       After the cycle that writes buf[NR], go to DONE. key_valid is ignored in EXPAND.
//     DONE: keys_ready=1, key_ready=1. On key_valid: buf[0]<=key_in, keys_ready<=0, cnt<=1,
//       go to EXPAND. Old keys become unreadable from the next cycle.
//   Expansion, with w0..w3 = previous key words and w3 the last word:
//     t = SubWord(RotWord(w3)) ^ Rcon(cnt);
//     n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
//     RotWord: {b1,b2,b3,b0}. SubWord applies the FIPS-197 S-box to each byte.
//     Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the MS byte, low 24 bits zero.
//     All XORs are 32-bit with no carries. Exactly one word-chain is computed per cycle.
//   Latency: handshake at edge E0 writes buf[0]. buf[r] is written at edge E0+r.
//     keys_ready rises after edge E0+NR, i.e. 11 edges after acceptance.
//     busy is high for exactly NR cycles.
//   Read port: 1-cycle latency. At each edge rk_out<=buf[rk_idx] and rk_out_valid<=keys_ready.
//     If rk_idx>NR: rk_out<=0 and rk_out_valid<=0.
//     During EXPAND, rk_out_valid=0 regardless of rk_idx.
//   Simultaneous events: a key accepted in DONE in the same cycle as a read returns the OLD
//     buf[rk_idx] with rk_out_valid=1. The following read returns rk_out_valid=0.
//   The counter never wraps: cnt saturates to 0 in IDLE/DONE.
// TESTING
//   1. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c -> buf[1]=a0fafe1788542cb123a339392a6c7605,
//      buf[10]=d014f9a8c9ee2589e13f0cc8b6630ca6, keys_ready exactly 11 edges after the handshake.
//   2. Read rk_idx=0..10 after keys_ready -> rk_out equals the A.1 schedule one cycle later.
//      rk_idx=11 and rk_idx=15 -> rk_out=0, rk_out_valid=0.
//   3. Assert key_valid with key=000...0 during EXPAND -> ignored, key_ready=0, and the A.1
//      results are unchanged.
//   4. Load a new key 000102030405060708090a0b0c0d0e0f in DONE -> keys_ready drops next cycle.
//      Afterwards buf[10]=13111d7fe3944a17f307a78b4d2b30c5.
//   5. Pulse rst_n low at expansion cycle 5 -> all outputs take their reset values immediately.
//      A reload then completes normally with the correct A.1 keys.
//   6. Back-to-back: key accepted on the same cycle keys_ready is first high -> busy=1 for 10
//      cycles, no lost or duplicated round.

Source files
------------

// File: rtl/round_key_sequencer.sv
// round_key_sequencer: sequential AES-128 key schedule with an 11-entry round-key buffer
// and a registered indexed read port.
module round_key_sequencer #(
  parameter int NK   = 4,
  parameter int NR   = NK + 6,
  parameter int RK_W = 32 * NK
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RK_W-1:0] key_in,
  input  logic            key_valid,
  output logic            key_ready,
  output logic            busy,
  output logic            keys_ready,
  input  logic [3:0]      rk_idx,
  output logic [RK_W-1:0] rk_out,
  output logic            rk_out_valid
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  localparam logic [3:0] NR4 = 4'(NR);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  if (NK != 4) begin : g_nk_check
    $error("round_key_sequencer supports NK=4 only");
  end
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] c);
    case (c)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
  state_t          r_state, w_next;
  logic [3:0]      r_cnt;
  logic [RK_W-1:0] r_buf [NR+1];
  logic [RK_W-1:0] w_prev, w_new;
  logic [31:0]     w_rot, w_t, w_n0, w_n1, w_n2, w_n3;
  assign key_ready  = r_state != EXPAND;
  assign busy       = r_state == EXPAND;
  assign keys_ready = r_state == DONE;
  always_comb begin
    w_prev = r_buf[r_cnt == 4'd0 ? 4'd0 : r_cnt - 4'd1];
    w_rot  = {w_prev[23:0], w_prev[31:24]};
    w_t    = {sub_byte(w_rot[31:24]) ^ rcon(r_cnt), sub_byte(w_rot[23:16]),
              sub_byte(w_rot[15:8]), sub_byte(w_rot[7:0])};
    w_n0   = w_prev[127:96] ^ w_t;
    w_n1   = w_prev[95:64] ^ w_n0;
    w_n2   = w_prev[63:32] ^ w_n1;
    w_n3   = w_prev[31:0] ^ w_n2;
    w_new  = {w_n0, w_n1, w_n2, w_n3};
    w_next = (r_state == EXPAND) ? ((r_cnt == NR4) ? DONE : EXPAND)
                                 : (key_valid ? EXPAND : r_state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      for (int i = 0; i <= NR; i++) r_buf[i] <= '0;
      rk_out       <= '0;
      rk_out_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == EXPAND) begin
        r_buf[r_cnt] <= w_new;
        r_cnt        <= (r_cnt == NR4) ? 4'd0 : r_cnt + 4'd1;
      end else if (key_valid) begin
        r_buf[0] <= key_in;
        r_cnt    <= 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end
      // a read in the accept cycle still sees the old buffer and the old keys_ready
      rk_out       <= (rk_idx <= NR4) ? r_buf[rk_idx] : '0;
      rk_out_valid <= keys_ready && (rk_idx <= NR4);
    end
  end
endmodule

// File: tb/tb_round_key_sequencer.sv
// tb_round_key_sequencer: directed vectors with a read-port scoreboard for round_key_sequencer
module tb_round_key_sequencer;
  logic         clk, rst_n, key_valid, key_ready, busy, keys_ready, rk_out_valid;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_idx;
  int checks, errors;
  typedef struct {logic [127:0] d; logic v; bit cd;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [127:0] a1 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  round_key_sequencer dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .busy(busy), .keys_ready(keys_ready), .rk_idx(rk_idx),
    .rk_out(rk_out), .rk_out_valid(rk_out_valid));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] i, input logic [127:0] d, input logic v, input bit cd);
    rk_idx = i;
    sb.push_back('{d, v, cd});
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
    chk("sb_drain", 128'(sb.size()), 128'd0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rd(4'(i), a1[i], 1'b1, 1'b1);
    end
    @(negedge clk);
    rd(4'd11, '0, 1'b0, 1'b1);
    @(negedge clk);
    rd(4'd15, '0, 1'b0, 1'b1);
    drain();
  endtask

  // called at a negedge; returns at the negedge after the handshake edge
  task automatic start(input logic [127:0] k);
    chk("key_ready_idle", 128'(key_ready), 128'd1);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    chk("keys_ready_drop", 128'(keys_ready), 128'd0);
    chk("busy_rise", 128'(busy), 128'd1);
  endtask

  task automatic run(input bit inject, input int rst_at);
    int edges, busy_cnt;
    bit stop;
    edges = 1;
    busy_cnt = 0;
    stop = 1'b0;
    while (!keys_ready && edges < 40 && !stop) begin
      if (busy) busy_cnt++;
      if (inject && edges == 3) begin
        chk("key_ready_expand", 128'(key_ready), 128'd0);
        key_in    = '0;
        key_valid = 1'b1;
      end
      if (inject && edges == 5) key_valid = 1'b0;
      if (edges == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_keys_ready", 128'(keys_ready), 128'd0);
        chk("rst_rk_out", rk_out, '0);
        chk("rst_rk_out_valid", 128'(rk_out_valid), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stop = 1'b1;
      end else begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
    if (!stop) begin
      chk("edges_to_keys_ready", 128'(edges), 128'd11);
      chk("busy_cycles", 128'(busy_cnt), 128'd10);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rk_out_valid", 128'(rk_out_valid), 128'(e.v));
        if (e.cd) chk("rk_out", rk_out, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_in = '0;
    rk_idx = 4'd0;
    @(negedge clk);
    chk("reset_key_ready", 128'(key_ready), 128'd1);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_keys_ready", 128'(keys_ready), 128'd0);
    chk("reset_rk_out", rk_out, '0);
    chk("reset_rk_out_valid", 128'(rk_out_valid), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start(a1[0]);
    run(1'b1, 0);
    read_all();
    @(negedge clk);
    start(K2);
    run(1'b0, 0);
    @(negedge clk); rd(4'd0, K2, 1'b1, 1'b1);
    @(negedge clk); rd(4'd1, K2_R1, 1'b1, 1'b1);
    @(negedge clk); rd(4'd10, K2_R10, 1'b1, 1'b1);
    drain();
    @(negedge clk);
    start(K2);
    run(1'b0, 0);
    rd(4'd10, K2_R10, 1'b1, 1'b1);
    start(a1[0]);
    rd(4'd10, '0, 1'b0, 1'b0);
    run(1'b0, 0);
    read_all();
    @(negedge clk);
    start(K2);
    run(1'b0, 5);
    start(a1[0]);
    run(1'b0, 0);
    read_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
